// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

   localparam int NB_INSTRUCT_DEF = 32;
   localparam int NB_PC_DEF       = 9;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, loader and IF/ID signals of the fetch stage; slave = fetch stage side.
interface instruction_fetch_if
   import instruction_fetch_pkg::*;
#(
   parameter int NB_INSTRUCT = NB_INSTRUCT_DEF,
   parameter int NB_PC       = NB_PC_DEF
);
   logic                   i_start;
   logic                   i_enable;
   logic                   i_PC_write;
   logic                   i_branch_taken;
   logic [NB_PC-1:0]       i_branch_target;
   logic                   i_jump;
   logic [NB_PC-1:0]       i_jump_target;
   logic                   i_load_en;
   logic [NB_PC-1:0]       i_load_addr;
   logic [NB_INSTRUCT-1:0] i_load_data;
   logic [NB_INSTRUCT-1:0] o_instruction;
   logic [NB_PC-1:0]       o_PC;
   logic                   o_halt;
   logic [NB_PC-1:0]       o_PC_current;

   modport master (
      output i_start, i_enable, i_PC_write,
      output i_branch_taken, i_branch_target, i_jump, i_jump_target,
      output i_load_en, i_load_addr, i_load_data,
      input  o_instruction, o_PC, o_halt, o_PC_current
   );

   modport slave (
      input  i_start, i_enable, i_PC_write,
      input  i_branch_taken, i_branch_target, i_jump, i_jump_target,
      input  i_load_en, i_load_addr, i_load_data,
      output o_instruction, o_PC, o_halt, o_PC_current
   );
endinterface

// File: rtl/instruction_fetch_imem.sv
// Instruction memory: synchronous write port for the loader, asynchronous read at PC.
module instruction_memory #(
   parameter int NB_INSTRUCT = 32,
   parameter int NB_PC       = 9
) (
   input  logic                   i_clk,
   input  logic                   wr_en,
   input  logic [NB_PC-1:0]       wr_addr,
   input  logic [NB_INSTRUCT-1:0] wr_data,
   input  logic [NB_PC-1:0]       rd_addr,
   output logic [NB_INSTRUCT-1:0] rd_data
);
   // No reset: program contents must survive a pipeline reset.
   logic [NB_INSTRUCT-1:0] mem [2**NB_PC];

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, LOAD/RUN/HALT sequencing.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | loader may write memory, PC held at 0, NOP presented
// ST_RUN  | fetch mem[PC] each enabled cycle, obey stalls and redirects
// ST_HALT | HALT word accepted, PC frozen, NOP presented until reset
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int NB_INSTRUCT = NB_INSTRUCT_DEF,
   parameter int NB_PC       = NB_PC_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   instruction_fetch_if.slave  fetch
);
   fetch_state_t           state_q, state_d;
   logic [NB_PC-1:0]       pc_q, pc_d;
   logic [NB_PC-1:0]       pc_plus1;
   logic [NB_INSTRUCT-1:0] mem_rdata;
   logic                   mem_we;
   logic                   is_halt_word;

   assign pc_plus1     = pc_q + NB_PC'(1);
   assign mem_we       = (state_q == ST_LOAD) && fetch.i_load_en;
   assign is_halt_word = (mem_rdata == NB_INSTRUCT'(HALT_WORD));

   instruction_memory #(
      .NB_INSTRUCT (NB_INSTRUCT),
      .NB_PC       (NB_PC)
   ) u_imem (
      .i_clk   (i_clk),
      .wr_en   (mem_we),
      .wr_addr (fetch.i_load_addr),
      .wr_data (fetch.i_load_data),
      .rd_addr (pc_q),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_LOAD;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_LOAD: begin
            pc_d = '0;
            if (fetch.i_start) state_d = ST_RUN;
         end
         ST_RUN: begin
            // Redirects outrank the HALT check: a HALT fetched on the wrong path is squashed.
            if (fetch.i_enable && fetch.i_PC_write) begin
               if (fetch.i_branch_taken)  pc_d = fetch.i_branch_target;
               else if (fetch.i_jump)     pc_d = fetch.i_jump_target;
               else if (is_halt_word)     state_d = ST_HALT;
               else                       pc_d = pc_plus1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_LOAD;
            pc_d    = '0;
         end
      endcase
   end

   assign fetch.o_instruction = (state_q == ST_RUN) ? mem_rdata : NB_INSTRUCT'(NOP_WORD);
   assign fetch.o_PC          = pc_plus1;
   assign fetch.o_halt        = (state_q == ST_HALT);
   assign fetch.o_PC_current  = pc_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run/halt, stalls, redirects, wrap, reset.
module tb_instruction_fetch;
   localparam int NB_INSTRUCT = 32;
   localparam int NB_PC       = 9;

   logic i_clk = 1'b0;
   logic i_reset;
   int   checks = 0;
   int   errors = 0;

   instruction_fetch_if #(.NB_INSTRUCT(NB_INSTRUCT), .NB_PC(NB_PC)) fetch_if ();

   instruction_fetch #(.NB_INSTRUCT(NB_INSTRUCT), .NB_PC(NB_PC)) u_dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .fetch   (fetch_if)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_if.i_start         = 1'b0;
      fetch_if.i_enable        = 1'b1;
      fetch_if.i_PC_write      = 1'b1;
      fetch_if.i_branch_taken  = 1'b0;
      fetch_if.i_branch_target = '0;
      fetch_if.i_jump          = 1'b0;
      fetch_if.i_jump_target   = '0;
      fetch_if.i_load_en       = 1'b0;
      fetch_if.i_load_addr     = '0;
      fetch_if.i_load_data     = '0;
   endtask

   task automatic load_word(input logic [NB_PC-1:0] addr, input logic [31:0] data);
      fetch_if.i_load_en   = 1'b1;
      fetch_if.i_load_addr = addr;
      fetch_if.i_load_data = data;
      step();
      fetch_if.i_load_en   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
      checks++;
      if (fetch_if.o_PC_current !== 9'd0) begin
         errors++; $display("FAIL reset_pc got=%0d exp=0", fetch_if.o_PC_current);
      end
      checks++;
      if (fetch_if.o_PC !== 9'd1) begin
         errors++; $display("FAIL reset_o_pc got=%0d exp=1", fetch_if.o_PC);
      end
      checks++;
      if (fetch_if.o_halt !== 1'b0) begin
         errors++; $display("FAIL reset_halt got=%b exp=0", fetch_if.o_halt);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'h0) begin
         errors++; $display("FAIL reset_instr got=%h exp=00000000", fetch_if.o_instruction);
      end
   endtask

   // Runs the 3-word program from PC 0 to the HALT at address 2; start is pulsed by caller.
   task automatic run_to_halt(input string tag);
      logic [31:0] exp_instr [3];
      exp_instr[0] = 32'h2001_0005;
      exp_instr[1] = 32'h2002_0003;
      exp_instr[2] = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (fetch_if.o_PC_current !== 9'(i)) begin
            errors++; $display("FAIL %s_pc%0d got=%0d exp=%0d", tag, i, fetch_if.o_PC_current, i);
         end
         checks++;
         if (fetch_if.o_instruction !== exp_instr[i]) begin
            errors++; $display("FAIL %s_instr%0d got=%h exp=%h", tag, i, fetch_if.o_instruction, exp_instr[i]);
         end
         checks++;
         if (fetch_if.o_halt !== 1'b0) begin
            errors++; $display("FAIL %s_early_halt%0d got=%b exp=0", tag, i, fetch_if.o_halt);
         end
         step();
      end
      checks++;
      if (fetch_if.o_halt !== 1'b1) begin
         errors++; $display("FAIL %s_halt got=%b exp=1", tag, fetch_if.o_halt);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'h0) begin
         errors++; $display("FAIL %s_halt_nop got=%h exp=00000000", tag, fetch_if.o_instruction);
      end
      checks++;
      if (fetch_if.o_PC_current !== 9'd2) begin
         errors++; $display("FAIL %s_halt_pc got=%0d exp=2", tag, fetch_if.o_PC_current);
      end
   endtask

   task automatic test_load_run_halt();
      load_word(9'd0, 32'h2001_0005);
      load_word(9'd1, 32'h2002_0003);
      // Final write coincides with start: write must land before RUN begins.
      fetch_if.i_start     = 1'b1;
      fetch_if.i_load_en   = 1'b1;
      fetch_if.i_load_addr = 9'd2;
      fetch_if.i_load_data = 32'hFFFF_FFFF;
      step();
      fetch_if.i_start   = 1'b0;
      fetch_if.i_load_en = 1'b0;
      run_to_halt("first_run");
      // Loader write while halted must be ignored.
      load_word(9'd0, 32'hDEAD_BEEF);
      checks++;
      if (fetch_if.o_PC_current !== 9'd2 || fetch_if.o_halt !== 1'b1) begin
         errors++; $display("FAIL halt_frozen pc=%0d halt=%b exp pc=2 halt=1", fetch_if.o_PC_current, fetch_if.o_halt);
      end
   endtask

   task automatic load_program2();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      load_word(9'd4,   32'h1111_1111);
      load_word(9'd5,   32'hFFFF_FFFF);
      load_word(9'd7,   32'h7777_7777);
      load_word(9'd10,  32'hAAAA_AAAA);
      load_word(9'd12,  32'hCCCC_CCCC);
      load_word(9'd20,  32'h1414_1414);
      load_word(9'd511, 32'h1FF1_FF1F);
      fetch_if.i_start = 1'b1;
      step();
      fetch_if.i_start = 1'b0;
   endtask

   task automatic test_stall_branch();
      fetch_if.i_jump        = 1'b1;
      fetch_if.i_jump_target = 9'd4;
      step();
      fetch_if.i_jump        = 1'b0;
      checks++;
      if (fetch_if.o_PC_current !== 9'd4) begin
         errors++; $display("FAIL jump_to4 got=%0d exp=4", fetch_if.o_PC_current);
      end
      fetch_if.i_PC_write      = 1'b0;
      fetch_if.i_branch_taken  = 1'b1;
      fetch_if.i_branch_target = 9'd20;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (fetch_if.o_PC_current !== 9'd4) begin
            errors++; $display("FAIL stall_hold%0d got=%0d exp=4", i, fetch_if.o_PC_current);
         end
      end
      fetch_if.i_PC_write = 1'b1;
      step();
      fetch_if.i_branch_taken = 1'b0;
      checks++;
      if (fetch_if.o_PC_current !== 9'd20) begin
         errors++; $display("FAIL stall_release got=%0d exp=20", fetch_if.o_PC_current);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'h1414_1414) begin
         errors++; $display("FAIL instr_at20 got=%h exp=14141414", fetch_if.o_instruction);
      end
   endtask

   task automatic test_branch_vs_jump();
      fetch_if.i_jump        = 1'b1;
      fetch_if.i_jump_target = 9'd7;
      step();
      checks++;
      if (fetch_if.o_instruction !== 32'h7777_7777) begin
         errors++; $display("FAIL instr_at7 got=%h exp=77777777", fetch_if.o_instruction);
      end
      fetch_if.i_jump_target   = 9'd30;
      fetch_if.i_branch_taken  = 1'b1;
      fetch_if.i_branch_target = 9'd10;
      step();
      fetch_if.i_jump         = 1'b0;
      fetch_if.i_branch_taken = 1'b0;
      checks++;
      if (fetch_if.o_PC_current !== 9'd10) begin
         errors++; $display("FAIL branch_wins got=%0d exp=10", fetch_if.o_PC_current);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'hAAAA_AAAA) begin
         errors++; $display("FAIL instr_at10 got=%h exp=aaaaaaaa", fetch_if.o_instruction);
      end
   endtask

   task automatic test_halt_wrong_path();
      fetch_if.i_branch_taken  = 1'b1;
      fetch_if.i_branch_target = 9'd5;
      step();
      checks++;
      if (fetch_if.o_instruction !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL instr_at5 got=%h exp=ffffffff", fetch_if.o_instruction);
      end
      fetch_if.i_branch_target = 9'd12;
      step();
      fetch_if.i_branch_taken = 1'b0;
      checks++;
      if (fetch_if.o_PC_current !== 9'd12 || fetch_if.o_halt !== 1'b0) begin
         errors++; $display("FAIL wrong_path_halt pc=%0d halt=%b exp pc=12 halt=0", fetch_if.o_PC_current, fetch_if.o_halt);
      end
   endtask

   task automatic test_wrap();
      fetch_if.i_jump        = 1'b1;
      fetch_if.i_jump_target = 9'd511;
      step();
      fetch_if.i_jump = 1'b0;
      checks++;
      if (fetch_if.o_PC !== 9'd0) begin
         errors++; $display("FAIL wrap_o_pc got=%0d exp=0", fetch_if.o_PC);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'h1FF1_FF1F) begin
         errors++; $display("FAIL instr_at511 got=%h exp=1ff1ff1f", fetch_if.o_instruction);
      end
      load_word(9'd0, 32'hDEAD_BEEF);
      checks++;
      if (fetch_if.o_PC_current !== 9'd0) begin
         errors++; $display("FAIL wrap_pc got=%0d exp=0", fetch_if.o_PC_current);
      end
      checks++;
      if (fetch_if.o_instruction !== 32'h2001_0005) begin
         errors++; $display("FAIL run_load_ignored got=%h exp=20010005", fetch_if.o_instruction);
      end
   endtask

   task automatic test_halt_stall();
      fetch_if.i_jump        = 1'b1;
      fetch_if.i_jump_target = 9'd5;
      step();
      fetch_if.i_jump     = 1'b0;
      fetch_if.i_PC_write = 1'b0;
      step();
      checks++;
      if (fetch_if.o_halt !== 1'b0 || fetch_if.o_PC_current !== 9'd5) begin
         errors++; $display("FAIL halt_in_stall halt=%b pc=%0d exp halt=0 pc=5", fetch_if.o_halt, fetch_if.o_PC_current);
      end
      fetch_if.i_PC_write = 1'b1;
      fetch_if.i_enable   = 1'b0;
      step();
      checks++;
      if (fetch_if.o_halt !== 1'b0 || fetch_if.o_instruction !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL halt_disabled halt=%b instr=%h exp halt=0 instr=ffffffff", fetch_if.o_halt, fetch_if.o_instruction);
      end
      fetch_if.i_enable = 1'b1;
      step();
      checks++;
      if (fetch_if.o_halt !== 1'b1 || fetch_if.o_PC_current !== 9'd5) begin
         errors++; $display("FAIL halt_release halt=%b pc=%0d exp halt=1 pc=5", fetch_if.o_halt, fetch_if.o_PC_current);
      end
   endtask

   task automatic test_reset_rerun();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      checks++;
      if (fetch_if.o_halt !== 1'b0 || fetch_if.o_PC_current !== 9'd0 || fetch_if.o_instruction !== 32'h0) begin
         errors++; $display("FAIL reset_from_halt halt=%b pc=%0d instr=%h exp halt=0 pc=0 instr=0",
                            fetch_if.o_halt, fetch_if.o_PC_current, fetch_if.o_instruction);
      end
      fetch_if.i_start = 1'b1;
      step();
      fetch_if.i_start = 1'b0;
      run_to_halt("rerun");
   endtask

   initial begin
      test_reset();
      test_load_run_halt();
      load_program2();
      test_stall_branch();
      test_branch_vs_jump();
      test_halt_wrong_path();
      test_wrap();
      test_halt_stall();
      test_reset_rerun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
